// File: rtl/m_areg_arbiter.sv
// Round-robin arbiter between the data-side and instruction-side access registers onto one memory port.
// Optional WAIT timeout is enabled by defining M_ARB_TIMEOUT_EN.
module m_areg_arbiter #(
  parameter int FLIT_W      = 144,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] d_m_areg_flits,
  input  logic              d_m_areg_state,
  input  logic [FLIT_W-1:0] i_m_areg_flits,
  input  logic              i_m_areg_state,
  input  logic              mem_rdy,
  input  logic              mem_ack,
  output logic [FLIT_W-1:0] mem_flits,
  output logic              v_mem_flits,
  output logic              d_mem_done_access,
  output logic              i_mem_done_access,
  output logic [1:0]        arb_grant,
  output logic              arb_timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t     state_reg, state_next;
  logic [1:0] grant_reg, grant_next;
  // Set when the instruction side was served last; reset value favours data.
  logic       last_instr_reg, last_instr_next;

`ifdef M_ARB_TIMEOUT_EN
  logic [7:0] cnt_reg, cnt_next;
  logic       err_reg, err_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 2'b00;
      last_instr_reg <= 1'b1;
`ifdef M_ARB_TIMEOUT_EN
      cnt_reg        <= 8'd0;
      err_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_instr_reg <= last_instr_next;
`ifdef M_ARB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_instr_next = last_instr_reg;
`ifdef M_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    err_next        = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (d_m_areg_state || i_m_areg_state) begin
          if (d_m_areg_state && i_m_areg_state)
            grant_next = last_instr_reg ? 2'b01 : 2'b10;
          else if (d_m_areg_state)
            grant_next = 2'b01;
          else
            grant_next = 2'b10;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rdy) begin
          state_next = WAIT;
`ifdef M_ARB_TIMEOUT_EN
          cnt_next   = 8'd0;
`endif
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_next = DONE;
        end
`ifdef M_ARB_TIMEOUT_EN
        else if (cnt_reg + 8'd1 == TIMEOUT_LIM) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      DONE: begin
        state_next      = IDLE;
        grant_next      = 2'b00;
        last_instr_next = grant_reg[1];
      end
      default: state_next = IDLE;
    endcase
  end

  assign v_mem_flits       = (state_reg == ISSUE);
  assign mem_flits         = !v_mem_flits  ? '0 :
                             grant_reg[0]  ? d_m_areg_flits : i_m_areg_flits;
  // Grant is one-hot, so at most one done pulse can be active.
  assign d_mem_done_access = (state_reg == DONE) && grant_reg[0];
  assign i_mem_done_access = (state_reg == DONE) && grant_reg[1];
  assign arb_grant         = grant_reg;

`ifdef M_ARB_TIMEOUT_EN
  assign arb_timeout_err = err_reg;
`else
  // Timeout limit only matters when the counter is built in.
  logic unused_timeout_lim;
  assign unused_timeout_lim = |TIMEOUT_LIM;
  assign arb_timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_m_areg_arbiter.sv
// Directed bench for m_areg_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_m_areg_arbiter;
  localparam int FW = 144;
`ifdef M_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] d_m_areg_flits, i_m_areg_flits;
  logic          d_m_areg_state, i_m_areg_state, mem_rdy, mem_ack;
  logic [FW-1:0] mem_flits;
  logic          v_mem_flits, d_mem_done_access, i_mem_done_access, arb_timeout_err;
  logic [1:0]    arb_grant;

  int errors = 0;
  int checks = 0;

  m_areg_arbiter #(.FLIT_W(FW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .d_m_areg_flits(d_m_areg_flits), .d_m_areg_state(d_m_areg_state),
    .i_m_areg_flits(i_m_areg_flits), .i_m_areg_state(i_m_areg_state),
    .mem_rdy(mem_rdy), .mem_ack(mem_ack),
    .mem_flits(mem_flits), .v_mem_flits(v_mem_flits),
    .d_mem_done_access(d_mem_done_access), .i_mem_done_access(i_mem_done_access),
    .arb_grant(arb_grant), .arb_timeout_err(arb_timeout_err)
  );

  always #5 clk = ~clk;

  // Transaction model: who owns the port, whether the flit went out, whether completion is due.
  int m_owner;   // 0 none, 1 data, 2 instruction
  int m_last;    // side served last
  int m_wc;
  bit m_sent, m_done, m_err;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_last = 2; m_wc = 0; m_sent = 0; m_done = 0; m_err = 0;
    end else if (m_done) begin
      m_last = m_owner; m_owner = 0; m_done = 0; m_sent = 0;
    end else if (m_owner == 0) begin
      if (d_m_areg_state && i_m_areg_state) m_owner = (m_last == 1) ? 2 : 1;
      else if (d_m_areg_state)              m_owner = 1;
      else if (i_m_areg_state)              m_owner = 2;
    end else if (!m_sent) begin
      if (mem_rdy) begin m_sent = 1; m_wc = 0; end
    end else if (mem_ack) begin
      m_done = 1;
    end else begin
      m_wc++;
`ifdef M_ARB_TIMEOUT_EN
      if (m_wc == TO) begin m_done = 1; m_err = 1; end
`endif
    end
    started = 1'b1;
  end

  // Per-cycle compare plus monitors used by the literal checks.
  logic [FW-1:0] e_flits, last_flit;
  logic          e_v, e_dd, e_id;
  logic [1:0]    e_grant, last_v_grant;
  int v_cnt = 0, d_cnt = 0, i_cnt = 0, overlap = 0;
  int order[$];

  always @(negedge clk) begin
    if (started) begin
      e_v     = (m_owner != 0) && !m_sent;
      e_flits = !e_v ? '0 : (m_owner == 1) ? d_m_areg_flits : i_m_areg_flits;
      e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      e_dd    = m_done && (m_owner == 1);
      e_id    = m_done && (m_owner == 2);
      checks++;
      if ({v_mem_flits, arb_grant, d_mem_done_access, i_mem_done_access, arb_timeout_err, mem_flits} !==
          {e_v, e_grant, e_dd, e_id, m_err, e_flits}) begin
        errors++;
        $display("FAIL cycle_model t=%0t got v=%b g=%b dd=%b id=%b err=%b flit=%h exp v=%b g=%b dd=%b id=%b err=%b flit=%h",
                 $time, v_mem_flits, arb_grant, d_mem_done_access, i_mem_done_access, arb_timeout_err, mem_flits,
                 e_v, e_grant, e_dd, e_id, m_err, e_flits);
      end
      if (v_mem_flits) begin v_cnt++; last_flit = mem_flits; last_v_grant = arb_grant; end
      if (d_mem_done_access) begin d_cnt++; order.push_back(1); end
      if (i_mem_done_access) begin i_cnt++; order.push_back(2); end
      if (d_mem_done_access && i_mem_done_access) overlap++;
    end
  end

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_flit(string name, logic [FW-1:0] got, logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
  endtask

  // Memory-side responder: wait for the issue, apply rdy/ack delays, then clear the served requester.
  task automatic run_txn(int rdy_dly, int ack_dly);
    int n;
    logic [1:0] g;
    n = 0;
    while (!v_mem_flits && n < 20) begin cyc(1); n++; end
    check_int("issue_seen", int'(v_mem_flits), 1);
    mem_rdy = 1'b0; cyc(rdy_dly);
    mem_rdy = 1'b1; cyc(1);
    mem_rdy = 1'b0; cyc(ack_dly);
    mem_ack = 1'b1; cyc(1);
    mem_ack = 1'b0;
    g = arb_grant;
    cyc(1);
    if (g[0]) d_m_areg_state = 1'b0;
    if (g[1]) i_m_areg_state = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] pat_a5, pat_3c, pat_be, pat_77;
    int v0, d0, i0, k;
    pat_a5 = {18{8'hA5}};
    pat_3c = {18{8'h3C}};
    pat_be = {9{16'hBEEF}};
    pat_77 = {18{8'h77}};
    rst = 1'b1; d_m_areg_state = 0; i_m_areg_state = 0; mem_rdy = 0; mem_ack = 0;
    d_m_areg_flits = '0; i_m_areg_flits = '0;
    cyc(2); rst = 1'b0;
    check_int("reset_outputs",
              int'({v_mem_flits, arb_grant, d_mem_done_access, i_mem_done_access, arb_timeout_err}), 0);
    check_flit("reset_flits", mem_flits, '0);

    // Single data request
    v0 = v_cnt; d0 = d_cnt; i0 = i_cnt;
    d_m_areg_flits = pat_a5; d_m_areg_state = 1'b1;
    run_txn(0, 2);
    cyc(2);
    check_int("t1_v_cycles", v_cnt - v0, 1);
    check_int("t1_grant", int'(last_v_grant), 1);
    check_flit("t1_flit", last_flit, pat_a5);
    check_int("t1_d_done", d_cnt - d0, 1);
    check_int("t1_i_done", i_cnt - i0, 0);

    // Simultaneous requests after reset: data first
    do_reset();
    order.delete();
    i_m_areg_flits = pat_3c;
    d_m_areg_state = 1'b1; i_m_areg_state = 1'b1;
    run_txn(0, 0);
    check_int("t2_first_grant", int'(last_v_grant), 1);
    run_txn(0, 0);
    check_int("t2_second_grant", int'(last_v_grant), 2);
    check_flit("t2_second_flit", last_flit, pat_3c);
    check_int("t2_done_count", order.size(), 2);
    if (order.size() == 2) begin
      check_int("t2_order0", order[0], 1);
      check_int("t2_order1", order[1], 2);
    end
    check_int("t2_overlap", overlap, 0);

    // Backpressure: 5 cycles of mem_rdy=0
    cyc(1);
    v0 = v_cnt;
    d_m_areg_flits = pat_be; d_m_areg_state = 1'b1;
    run_txn(5, 1);
    check_int("t3_v_cycles", v_cnt - v0, 6);
    check_flit("t3_flit", last_flit, pat_be);

    // Spurious acks in IDLE and ISSUE
    d0 = d_cnt; i0 = i_cnt;
    mem_ack = 1'b1; cyc(1); mem_ack = 1'b0; cyc(1);
    check_int("t4_idle_grant", int'(arb_grant), 0);
    i_m_areg_flits = pat_77; i_m_areg_state = 1'b1;
    cyc(1);
    mem_ack = 1'b1; cyc(1); mem_ack = 1'b0;
    check_int("t4_still_issue", int'(v_mem_flits), 1);
    check_int("t4_no_done", d_cnt + i_cnt - d0 - i0, 0);
    run_txn(0, 1);
    check_int("t4_i_done", i_cnt - i0, 1);
    check_int("t4_d_done", d_cnt - d0, 0);

    // Request dropped while granted still completes
    d0 = d_cnt;
    d_m_areg_state = 1'b1; cyc(1); d_m_areg_state = 1'b0;
    run_txn(1, 0);
    check_int("t5_drop_done", d_cnt - d0, 1);

    // Reset in WAIT aborts without a done pulse
    d0 = d_cnt; i0 = i_cnt;
    d_m_areg_state = 1'b1; cyc(1);
    mem_rdy = 1'b1; cyc(1); mem_rdy = 1'b0; cyc(1);
    check_int("t6_in_wait_grant", int'(arb_grant), 1);
    rst = 1'b1; cyc(1); rst = 1'b0; d_m_areg_state = 1'b0;
    check_int("t6_outputs",
              int'({v_mem_flits, arb_grant, d_mem_done_access, i_mem_done_access, arb_timeout_err}), 0);
    check_flit("t6_flits", mem_flits, '0);
    cyc(3);
    check_int("t6_no_done", d_cnt + i_cnt - d0 - i0, 0);

`ifdef M_ARB_TIMEOUT_EN
    // No ack: done after TO WAIT cycles, sticky error
    d0 = d_cnt;
    d_m_areg_state = 1'b1; cyc(1);
    mem_rdy = 1'b1; cyc(1); mem_rdy = 1'b0;
    k = 0;
    while (!d_mem_done_access && k < 50) begin k++; cyc(1); end
    check_int("t7_wait_cycles", k, 8);
    check_int("t7_err_set", int'(arb_timeout_err), 1);
    cyc(1); d_m_areg_state = 1'b0; cyc(5);
    check_int("t7_err_sticky", int'(arb_timeout_err), 1);
    check_int("t7_done_once", d_cnt - d0, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check_int("t7_err_cleared", int'(arb_timeout_err), 0);
`else
    // No ack: stays waiting indefinitely
    d0 = d_cnt;
    d_m_areg_state = 1'b1; cyc(1);
    mem_rdy = 1'b1; cyc(1); mem_rdy = 1'b0;
    cyc(300);
    check_int("t7_still_granted", int'(arb_grant), 1);
    check_int("t7_no_done", d_cnt - d0, 0);
    check_int("t7_no_err", int'(arb_timeout_err), 0);
    mem_ack = 1'b1; cyc(1); mem_ack = 1'b0;
    check_int("t7_done_pulse", int'(d_mem_done_access), 1);
    cyc(1); d_m_areg_state = 1'b0; cyc(2);
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
